// File: rtl/fb_pkg.sv
// Shared constants, state encoding and pixel addressing for the 40x30 one-bit framebuffer.
package fb_pkg;

    localparam int FB_W     = 40;
    localparam int FB_H     = 30;
    localparam int FB_BITS  = FB_W * FB_H;
    localparam int GLYPH_H  = 8;
    localparam int FB_IDX_W = 11;
    localparam int ROW_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        CLEAR
    } fb_wr_state_t;

    function automatic logic [FB_IDX_W-1:0] pix_idx(input logic [ROW_W-1:0] x,
                                                    input logic [ROW_W-1:0] y);
        return FB_IDX_W'(y) * FB_IDX_W'(FB_W) + FB_IDX_W'(x);
    endfunction

endpackage

// File: rtl/framebuffer_writer.sv
// Sequential erase-then-draw writer for per-slot 8-pixel vertical letter strips.
// Define FB_WRITER_CLEAR_EN to build the full-screen clear path driven by clear_req_i.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int COLUMNS    = 3,
    parameter int SLOT_BASE  = 10,
    parameter int SLOT_PITCH = 10
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_slot_i,
    input  logic [7:0]         req_letter_i,
    input  logic [4:0]         req_ypos_i,
    input  logic               clear_req_i,
    output logic               done_o,
    output logic [FB_BITS-1:0] framebuffer_o
);

    fb_wr_state_t state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [1:0]   slot_q, slot_d;
    logic [7:0]   letter_q, letter_d;
    logic [4:0]   ypos_q, ypos_d;
    logic         slot_ok_q, slot_ok_d;
    logic [4:0]   prev_ypos_q [COLUMNS];
    logic [FB_BITS-1:0] fb_q;

    logic [4:0]          prev_sel;
    logic [ROW_W-1:0]    slot_x;
    logic [ROW_W-1:0]    erase_row;
    logic [ROW_W-1:0]    draw_row;
    logic [ROW_W-1:0]    px_row;
    logic [FB_IDX_W-1:0] px_idx;
    logic                px_we;
    logic                px_val;
    logic                row_clr;
    logic                done_c;
    logic                prev_upd;
    logic                prev_rst;
    logic                last_glyph;

    // Slot-indexed lookup without ever indexing past COLUMNS-1.
    always_comb begin
        prev_sel = 5'd31;
        for (int j = 0; j < COLUMNS; j++) begin
            if (slot_q == 2'(j)) begin
                prev_sel = prev_ypos_q[j];
            end
        end
    end

    assign slot_x     = ROW_W'(SLOT_BASE + SLOT_PITCH * int'(slot_q));
    assign erase_row  = {1'b0, prev_sel} + {3'b000, cnt_q[2:0]};
    assign draw_row   = {1'b0, ypos_q} + {3'b000, cnt_q[2:0]};
    assign last_glyph = (cnt_q[2:0] == 3'(GLYPH_H - 1));
    assign px_idx     = pix_idx(slot_x, px_row);

`ifdef FB_WRITER_CLEAR_EN
    logic                last_row;
    logic [FB_IDX_W-1:0] clr_base;
    assign last_row = (cnt_q == 5'(FB_H - 1));
    assign clr_base = pix_idx(6'd0, {1'b0, cnt_q});
`else
    logic unused_clear;
    assign unused_clear = clear_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        letter_d  = letter_q;
        ypos_d    = ypos_q;
        slot_ok_d = slot_ok_q;
        px_we     = 1'b0;
        px_row    = erase_row;
        px_val    = 1'b0;
        row_clr   = 1'b0;
        done_c    = 1'b0;
        prev_upd  = 1'b0;
        prev_rst  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef FB_WRITER_CLEAR_EN
                if (clear_req_i) begin
                    state_d = CLEAR;
                end else
`endif
                if (req_valid_i) begin
                    slot_d    = req_slot_i;
                    letter_d  = req_letter_i;
                    ypos_d    = req_ypos_i;
                    slot_ok_d = (int'(req_slot_i) < COLUMNS);
                    // An out-of-range slot skips ERASE so done arrives 8 cycles after acceptance.
                    state_d   = (int'(req_slot_i) < COLUMNS) ? ERASE : DRAW;
                end
            end

            ERASE: begin
                px_row = erase_row;
                px_val = 1'b0;
                px_we  = slot_ok_q && (erase_row < ROW_W'(FB_H));
                cnt_d  = cnt_q + 5'd1;
                if (last_glyph) begin
                    cnt_d   = '0;
                    state_d = DRAW;
                end
            end

            DRAW: begin
                px_row = draw_row;
                px_val = letter_q[3'd7 - cnt_q[2:0]];
                px_we  = slot_ok_q && (draw_row < ROW_W'(FB_H));
                cnt_d  = cnt_q + 5'd1;
                if (last_glyph) begin
                    cnt_d    = '0;
                    done_c   = 1'b1;
                    prev_upd = slot_ok_q;
                    state_d  = IDLE;
                end
            end

`ifdef FB_WRITER_CLEAR_EN
            CLEAR: begin
                row_clr = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                if (last_row) begin
                    cnt_d    = '0;
                    done_c   = 1'b1;
                    prev_rst = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            letter_q  <= '0;
            ypos_q    <= '0;
            slot_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            letter_q  <= letter_d;
            ypos_q    <= ypos_d;
            slot_ok_q <= slot_ok_d;
        end
    end

    // 31 places a slot's first erase strip entirely below the visible rows.
    for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_prev
        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                prev_ypos_q[gi] <= 5'd31;
            end else if (prev_rst) begin
                prev_ypos_q[gi] <= 5'd31;
            end else if (prev_upd && (slot_q == 2'(gi))) begin
                prev_ypos_q[gi] <= ypos_q;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fb_q <= '0;
`ifdef FB_WRITER_CLEAR_EN
        end else if (row_clr) begin
            fb_q[clr_base +: FB_W] <= '0;
`endif
        end else if (px_we) begin
            fb_q[px_idx] <= px_val;
        end
    end

`ifndef FB_WRITER_CLEAR_EN
    logic unused_row_clr;
    assign unused_row_clr = row_clr | prev_rst;
`endif

    assign req_ready_o   = (state_q == IDLE);
    assign done_o        = done_c;
    assign framebuffer_o = fb_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed self-checking bench for framebuffer_writer; expected framebuffer built by hand per step.
module tb_framebuffer_writer;

    logic          clock_i = 1'b0;
    logic          reset_n_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [1:0]    req_slot_i;
    logic [7:0]    req_letter_i;
    logic [4:0]    req_ypos_i;
    logic          clear_req_i;
    logic          done_o;
    logic [1199:0] framebuffer_o;

    logic [1199:0] exp_fb;
    int checks   = 0;
    int failures = 0;
    int lat;

    framebuffer_writer #(.COLUMNS(3), .SLOT_BASE(10), .SLOT_PITCH(10)) dut (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_slot_i   (req_slot_i),
        .req_letter_i (req_letter_i),
        .req_ypos_i   (req_ypos_i),
        .clear_req_i  (clear_req_i),
        .done_o       (done_o),
        .framebuffer_o(framebuffer_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic check_fb(input string tag);
        int nd;
        int first;
        nd = 0;
        first = -1;
        for (int k = 0; k < 1200; k++) begin
            if (framebuffer_o[k] !== exp_fb[k]) begin
                nd++;
                if (first < 0) first = k;
            end
        end
        checks++;
        assert (framebuffer_o === exp_fb) else begin
            failures++;
            $error("FAIL %s: %0d pixels differ from expected, first differing index %0d", tag, nd, first);
        end
        $display("step %s: framebuffer compared, %0d differing pixels", tag, nd);
    endtask

    task automatic set_px(input int x, input int y, input logic v);
        exp_fb[y * 40 + x] = v;
    endtask

    // Called #1 after a rising edge; leaves the bench in cycle 1 of the operation.
    task automatic issue(input logic [1:0] s, input logic [7:0] l, input logic [4:0] y,
                         input logic clr, input string tag);
        check({tag, "_ready_pre"}, 32'(req_ready_o), 32'd1);
        req_slot_i   = s;
        req_letter_i = l;
        req_ypos_i   = y;
        req_valid_i  = 1'b1;
        clear_req_i  = clr;
        @(posedge clock_i);
        #1;
        req_valid_i  = 1'b0;
        clear_req_i  = 1'b0;
        req_slot_i   = 2'($urandom);
        req_letter_i = 8'($urandom);
        req_ypos_i   = 5'($urandom);
        check({tag, "_ready_busy"}, 32'(req_ready_o), 32'd0);
    endtask

    task automatic wait_done(output int n_out);
        n_out = -1;
        for (int n = 1; n <= 64; n++) begin
            if (done_o === 1'b1) begin
                n_out = n;
                break;
            end
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic finish_op(input string tag, input int want_lat);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(want_lat));
        @(posedge clock_i);
        #1;
        check({tag, "_done_low"}, 32'(done_o), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready_o), 32'd1);
        check_fb(tag);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        req_valid_i  = 1'b0;
        req_slot_i   = '0;
        req_letter_i = '0;
        req_ypos_i   = '0;
        clear_req_i  = 1'b0;
        exp_fb       = '0;
        #22;
        reset_n_i = 1'b1;
        @(posedge clock_i);
        #1;

        check("reset_ready", 32'(req_ready_o), 32'd1);
        check("reset_done", 32'(done_o), 32'd0);
        check_fb("reset_fb");

        // Slot 0, letter A5 at rows 4..11 of x=10 -> 1,0,1,0,0,1,0,1
        issue(2'd0, 8'hA5, 5'd4, 1'b0, "draw_a5");
        set_px(10, 4, 1'b1);
        set_px(10, 6, 1'b1);
        set_px(10, 9, 1'b1);
        set_px(10, 11, 1'b1);
        finish_op("draw_a5", 16);
        check("draw_a5_px_row5", 32'(framebuffer_o[5 * 40 + 10]), 32'd0);

        // Move slot 0 to ypos 6 with FF: old strip erased, rows 6..13 set
        issue(2'd0, 8'hFF, 5'd6, 1'b0, "move_ff");
        for (int r = 4; r <= 11; r++) set_px(10, r, 1'b0);
        for (int r = 6; r <= 13; r++) set_px(10, r, 1'b1);
        finish_op("move_ff", 16);

        // Slot 2 at ypos 26: only rows 26..29 of x=30 visible
        issue(2'd2, 8'hFF, 5'd26, 1'b0, "clip");
        for (int r = 26; r <= 29; r++) set_px(30, r, 1'b1);
        finish_op("clip", 16);

        // Invalid slot 3: no writes, done 8 cycles after acceptance
        issue(2'd3, 8'hFF, 5'd0, 1'b0, "bad_slot");
        finish_op("bad_slot", 8);

        // Slot 1, letter 81 at ypos 0: x=20 rows 0 and 7
        issue(2'd1, 8'h81, 5'd0, 1'b0, "draw_81");
        set_px(20, 0, 1'b1);
        set_px(20, 7, 1'b1);
        finish_op("draw_81", 16);

        // clear_req and req_valid together
`ifdef FB_WRITER_CLEAR_EN
        issue(2'd1, 8'h3C, 5'd10, 1'b1, "collide");
        exp_fb = '0;
        finish_op("collide", 30);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            if (done_o === 1'b1) lat++;
            @(posedge clock_i);
            #1;
        end
        check("collide_no_accept", 32'(lat), 32'd0);
        check_fb("collide_after");
`else
        issue(2'd1, 8'h3C, 5'd10, 1'b1, "collide");
        for (int r = 0; r <= 7; r++) set_px(20, r, 1'b0);
        for (int r = 12; r <= 15; r++) set_px(20, r, 1'b1);
        finish_op("collide", 16);
`endif

        // Asynchronous reset during DRAW cycle 12
        issue(2'd0, 8'hFF, 5'd0, 1'b0, "abort");
        for (int n = 0; n < 11; n++) begin
            @(posedge clock_i);
            #1;
        end
        check("abort_no_done_yet", 32'(done_o), 32'd0);
        #2;
        reset_n_i = 1'b0;
        #1;
        exp_fb = '0;
        check("abort_ready", 32'(req_ready_o), 32'd1);
        check("abort_done", 32'(done_o), 32'd0);
        check_fb("abort_fb");
        #2;
        reset_n_i = 1'b1;
        @(posedge clock_i);
        #1;
        check("abort_ready_after", 32'(req_ready_o), 32'd1);

        // After reset prev_ypos is 31 again: slot 2 at ypos 29, only row 29 visible
        issue(2'd2, 8'h80, 5'd29, 1'b0, "post_reset");
        set_px(30, 29, 1'b1);
        finish_op("post_reset", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Sequential writer for the 40x30 one-bit framebuffer that the VGA block scans out. Accepts per-column draw requests (game slot, 8-bit letter, 5-bit row position) over a valid/ready handshake. For each request it erases that slot's previous strip, then draws the letter as an 8-pixel vertical bit strip. It replaces the wide combinational render path between the game columns and the VGA reader, and presents the same 1200-bit flat framebuffer.

## Interface
- COLUMNS, 3: number of game slots tracked.
- SLOT_BASE, 10: x coordinate of slot 0.
- SLOT_PITCH, 10: x spacing between adjacent slots.
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  draw request present.
- req_ready  out  1  writer can accept a request. High only in IDLE.
- req_slot  in  2  slot index, 0..COLUMNS-1.
- req_letter  in  8  letter bits. Bit 7 is drawn at the top row.
- req_ypos  in  5  top row of the strip, 0..31.
- clear_req  in  1  one-cycle pulse requesting a full-screen clear.
- done  out  1  one-cycle pulse when an operation completes.
- framebuffer  out  1200  pixel (x,y) is at bit y*40+x, with x in 0..39 and y in 0..29.

## Operation
- States: IDLE, ERASE, DRAW, CLEAR.
- IDLE
  - req_ready=1.
  - clear_req=1 moves to CLEAR. This takes priority over a same-cycle req_valid, which is then not accepted.
  - Otherwise req_valid=1 latches slot, letter and ypos, then moves to ERASE.
- ERASE
  - Uses row counter i = 0..7.
  - Clears pixel (x_s, prev_ypos[slot]+i), where x_s = SLOT_BASE + slot*SLOT_PITCH.
  - Exits to DRAW after i=7.
- DRAW
  - Uses row counter i = 0..7.
  - Writes pixel (x_s, ypos+i) = letter[7-i].
  - After i=7: prev_ypos[slot] <= ypos, done=1, return to IDLE.
- CLEAR
  - Uses row counter r = 0..29.
  - Zeroes all 40 bits of row r, one row per cycle.
  - After r=29: reset every prev_ypos to 31, done=1, return to IDLE.
- Clipping
  - Row arithmetic is 6-bit: ypos+i ranges 0..38.
  - Any row >29 is skipped with no write, but the cycle is still spent. Latency is fixed.
- Invalid slot (req_slot >= COLUMNS)
  - The request is still accepted.
  - No ERASE or DRAW writes occur, and prev_ypos is untouched.
  - FSM goes IDLE -> DRAW with writes suppressed, so done fires 8 cycles after acceptance.
- Reset state
  - framebuffer = 0, state = IDLE, req_ready = 1, done = 0.
  - Every prev_ypos = 31, so the first ERASE for a slot is fully clipped.
- Asserting reset_n low mid-operation aborts the operation immediately. All state returns to reset values and partial writes are discarded.
- Inputs are sampled only on the acceptance cycle. Changes to req_* during ERASE or DRAW have no effect.

## Timing
- Acceptance at cycle 0 (req_valid & req_ready).
- ERASE occupies cycles 1-8, DRAW cycles 9-16, with done high in cycle 16.
- req_ready is high again in cycle 17, giving a sustained throughput of 1 request per 17 cycles.
- CLEAR: clear_req is sampled at cycle 0. Rows are zeroed in cycles 1-30, done is high in cycle 30, and req_ready returns in cycle 31.
- framebuffer is registered; each pixel write is visible the cycle after its state cycle.
- The VGA reader may sample framebuffer at any time, and tearing within a frame is acceptable.

## Configuration
- FB_WRITER_CLEAR_EN
  - When defined: the CLEAR state and the clear_req path are built as described above.
  - When undefined: clear_req remains a port but is ignored, and CLEAR is unreachable. The framebuffer is cleared only by reset.

## Structure
- Shared package fb_pkg:
  - Constants FB_W=40, FB_H=30, FB_BITS=1200, GLYPH_H=8.
  - State enum fb_wr_state_t with IDLE, ERASE, DRAW, CLEAR.
  - Pixel-index helper function (y*FB_W+x).
- framebuffer_writer is a single module with no sub-module needed.
- The prev_ypos array is COLUMNS x 5 bits of registers.

## Test plan
- Draw request: reset, then request slot 0, letter 8'hA5, ypos 4.
  - After done, column x=10 rows 4..11 read 1,0,1,0,0,1,0,1.
  - All other bits of the framebuffer are 0.
  - done fires at cycle 16.
- Move: a subsequent request for slot 0 with letter 8'hFF, ypos 6.
  - Rows 4-5 at x=10 become 0 and rows 6..13 become 1.
- Clipping: request slot 2, letter 8'hFF, ypos 26.
  - x=30 rows 26..29 are set to 1.
  - No bit outside rows 0..29 is written; the framebuffer index stays below 1200.
  - Latency is still 16 cycles.
- Collision of requests: clear_req and req_valid asserted together in IDLE.
  - CLEAR runs and the request is not accepted (no handshake).
  - Framebuffer reads all-zero at cycle 30.
  - With FB_WRITER_CLEAR_EN undefined, the request is accepted instead.
- Invalid slot: request slot 3 with COLUMNS=3.
  - Framebuffer is unchanged and done fires 8 cycles after acceptance.
- Reset mid-operation: drive reset_n low during DRAW cycle 12.
  - Framebuffer is 0, req_ready=1, done=0 immediately, without waiting for a clock edge.
